// File: rtl/ser_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit serializer among N_REQ requesters.
// One word is granted at a time; completion is tracked through the serializer busy flag.
//
// state      | meaning
// IDLE       | arbitrate and accept the winner in the grant cycle
// ISSUE      | wait for the serializer to be idle, then pulse the load strobe
// WAIT_START | expect busy to rise after the load, else flag an error
// WAIT_DONE  | wait for busy to fall, then report done to the owner
module ser_rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic [16*N_REQ-1:0]   req_data_i,
    input  logic [4*N_REQ-1:0]    req_mod_i,
    input  logic [N_REQ-1:0]      req_val_i,
    output logic [N_REQ-1:0]      req_ready_o,
    output logic [15:0]           ser_data_o,
    output logic [3:0]            ser_mod_o,
    output logic                  ser_val_o,
    input  logic                  ser_busy_i,
    output logic [ID_W-1:0]       owner_o,
    output logic                  owner_val_o,
    output logic [N_REQ-1:0]      done_o,
    output logic [N_REQ-1:0]      drop_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    localparam logic [ID_W:0]    N_EXT  = (ID_W+1)'(N_REQ);
    localparam logic [N_REQ-1:0] OH_ONE = N_REQ'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ID_W-1:0]  r_last;
    logic [ID_W-1:0]  r_owner;
    logic [ID_W-1:0]  w_win;
    logic             w_any;
    logic             w_accept;
    logic             w_illegal;
    logic [N_REQ-1:0] w_win_oh;
    logic [15:0]      w_win_data;
    logic [3:0]       w_win_mod;
    logic [15:0]      r_ser_data;
    logic [3:0]       r_ser_mod;
    logic [N_REQ-1:0] r_done;
    logic [N_REQ-1:0] r_drop;

    // Search last+1, last+2, ... with the index wrapped back into 0..N_REQ-1.
    always_comb begin : arbitrate
        logic [ID_W:0] v_idx;
        v_idx = '0;
        w_any = 1'b0;
        w_win = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            v_idx = {1'b0, r_last} + (ID_W+1)'(i);
            if (v_idx >= N_EXT) begin
                v_idx = v_idx - N_EXT;
            end
            if (!w_any && req_val_i[v_idx[ID_W-1:0]]) begin
                w_any = 1'b1;
                w_win = v_idx[ID_W-1:0];
            end
        end
    end

    assign w_win_oh   = OH_ONE << w_win;
    assign w_win_data = req_data_i[16*w_win +: 16];
    assign w_win_mod  = req_mod_i[4*w_win +: 4];
    assign w_illegal  = (w_win_mod == 4'd1) || (w_win_mod == 4'd2);
    assign w_accept   = (r_state == S_IDLE) && w_any && !arst_i;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept && !w_illegal) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!ser_busy_i) begin
                    w_state_nxt = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                w_state_nxt = ser_busy_i ? S_WAIT_DONE : S_IDLE;
            end
            S_WAIT_DONE: begin
                if (!ser_busy_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = w_accept ? w_win_oh : '0;
        ser_val_o   = (r_state == S_ISSUE) && !ser_busy_i;
        owner_val_o = (r_state != S_IDLE);
        err_o       = (r_state == S_WAIT_START) && !ser_busy_i;
    end

    // Illegal codes never touch the serializer-facing registers or the owner.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_last     <= ID_W'(N_REQ - 1);
            r_owner    <= '0;
            r_ser_data <= '0;
            r_ser_mod  <= '0;
            r_done     <= '0;
            r_drop     <= '0;
        end else begin
            r_done <= '0;
            r_drop <= '0;
            if (w_accept) begin
                r_last <= w_win;
                if (w_illegal) begin
                    r_drop <= w_win_oh;
                end else begin
                    r_ser_data <= w_win_data;
                    r_ser_mod  <= w_win_mod;
                    r_owner    <= w_win;
                end
            end
            if ((r_state == S_WAIT_DONE) && !ser_busy_i) begin
                r_done <= OH_ONE << r_owner;
            end
        end
    end

    assign ser_data_o = r_ser_data;
    assign ser_mod_o  = r_ser_mod;
    assign owner_o    = r_owner;
    assign done_o     = r_done;
    assign drop_o     = r_drop;

endmodule

// File: tb/tb_ser_rr_arbiter.sv
// Testbench for ser_rr_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-count reference model of the arbitration rules.
module tb_ser_rr_arbiter;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            arst = 1'b0;
    logic [16*N-1:0] req_data = '0;
    logic [4*N-1:0]  req_mod = '0;
    logic [N-1:0]    req_val = '0;
    logic [N-1:0]    req_ready;
    logic [15:0]     ser_data;
    logic [3:0]      ser_mod;
    logic            ser_val;
    logic            ser_busy;
    logic [1:0]      owner;
    logic            owner_val;
    logic [N-1:0]    done;
    logic [N-1:0]    drop;
    logic            err;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   busy_len = 4;
    logic never_busy = 1'b0;
    logic ext_busy = 1'b0;
    int   ser_cnt;

    ser_rr_arbiter #(.N_REQ(N)) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .req_data_i  (req_data),
        .req_mod_i   (req_mod),
        .req_val_i   (req_val),
        .req_ready_o (req_ready),
        .ser_data_o  (ser_data),
        .ser_mod_o   (ser_mod),
        .ser_val_o   (ser_val),
        .ser_busy_i  (ser_busy),
        .owner_o     (owner),
        .owner_val_o (owner_val),
        .done_o      (done),
        .drop_o      (drop),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    // Serializer model: busy for busy_len cycles starting the cycle after a load.
    always @(posedge clk or posedge arst) begin
        if (arst) ser_cnt <= 0;
        else if (ser_val && !never_busy) ser_cnt <= busy_len;
        else if (ser_cnt != 0) ser_cnt <= ser_cnt - 1;
    end
    assign ser_busy = (ser_cnt != 0) || ext_busy;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        req_val = '0;
        ext_busy = 1'b0;
        never_busy = 1'b0;
        #2 arst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 arst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (owner_val !== 1'b0 && k < 100) begin
            step();
            k++;
        end
        n_cmp++;
        if (owner_val !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle_timeout owner_val=%b exp=0", tag, owner_val);
        end
    endtask

    task automatic test_reset();
        req_val = 4'hF;
        #1 arst = 1'b1;
        #3;
        n_cmp++;
        if ({ser_val, ser_data, ser_mod, owner, owner_val, done, drop, err, req_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got val=%b data=%h mod=%h own=%h ov=%b done=%b drop=%b err=%b rdy=%b exp all 0",
                     ser_val, ser_data, ser_mod, owner, owner_val, done, drop, err, req_ready);
        end
        @(posedge clk);
        #1 arst = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_first_priority got=%b exp=0001", req_ready);
        end
        req_val = '0;
    endtask

    task automatic test_single();
        int done_cnt = 0;
        int done_at = -1;
        req_data[15:0] = 16'hA5C3;
        req_mod[3:0] = 4'd0;
        req_val = 4'b0001;
        busy_len = 17;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL single_ready got=%b exp=0001", req_ready);
        end
        step();
        req_val = '0;
        n_cmp++;
        if (ser_val !== 1'b1 || ser_data !== 16'hA5C3 || ser_mod !== 4'd0) begin
            n_bad++;
            $display("FAIL single_load got val=%b data=%h mod=%h exp 1/a5c3/0", ser_val, ser_data, ser_mod);
        end
        n_cmp++;
        if (owner !== 2'd0 || owner_val !== 1'b1) begin
            n_bad++;
            $display("FAIL single_owner got own=%0d ov=%b exp 0/1", owner, owner_val);
        end
        for (int k = 2; k <= 30; k++) begin
            step();
            if (done !== 4'b0000) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
                n_cmp++;
                if (done !== 4'b0001) begin
                    n_bad++;
                    $display("FAIL single_done_value got=%b exp=0001", done);
                end
            end
        end
        n_cmp++;
        if (done_cnt != 1 || done_at != 20) begin
            n_bad++;
            $display("FAIL single_done_timing got count=%0d at=T+%0d exp count=1 at=T+20", done_cnt, done_at);
        end
    endtask

    task automatic test_round_robin();
        int exp_id = 0;
        int grants = 0;
        int sv_cnt = 0;
        reset_dut();
        req_mod = 16'h4444;
        busy_len = 3;
        for (int j = 0; j < 150; j++) begin
            if (ser_val === 1'b1) sv_cnt++;
            req_val = 4'hF;
            req_data = {$urandom, $urandom};
            #1;
            if (req_ready !== 4'b0000) begin
                n_cmp++;
                if (req_ready !== 4'(1 << exp_id) || ser_busy !== 1'b0 || owner_val !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rr_grant got=%b busy=%b ov=%b exp grant to %0d while idle",
                             req_ready, ser_busy, owner_val, exp_id);
                end
                exp_id = (exp_id + 1) % N;
                grants++;
            end
            step();
        end
        req_val = '0;
        for (int j = 0; j < 20; j++) begin
            if (ser_val === 1'b1) sv_cnt++;
            step();
        end
        n_cmp++;
        if (grants != 25 || sv_cnt != grants) begin
            n_bad++;
            $display("FAIL rr_counts got grants=%0d loads=%0d exp 25/25", grants, sv_cnt);
        end
    endtask

    task automatic test_drop();
        reset_dut();
        req_mod = '0;
        req_mod[11:8] = 4'd2;
        req_mod[15:12] = 4'd5;
        req_val = 4'b1100;
        busy_len = 2;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL drop_ready got=%b exp=0100", req_ready);
        end
        step();
        n_cmp++;
        if (drop !== 4'b0100 || ser_val !== 1'b0 || owner_val !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_pulse got drop=%b val=%b ov=%b exp 0100/0/0", drop, ser_val, owner_val);
        end
        #1;
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            n_bad++;
            $display("FAIL drop_next_grant got=%b exp=1000", req_ready);
        end
        step();
        req_val = '0;
        n_cmp++;
        if (drop !== 4'b0000 || ser_val !== 1'b1 || ser_mod !== 4'd5 || owner !== 2'd3) begin
            n_bad++;
            $display("FAIL drop_followup got drop=%b val=%b mod=%0d own=%0d exp 0000/1/5/3",
                     drop, ser_val, ser_mod, owner);
        end
        wait_idle("drop");
    endtask

    task automatic test_err();
        logic [N-1:0] done_seen = '0;
        never_busy = 1'b1;
        req_mod[7:4] = 4'd0;
        req_val = 4'b0010;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL err_ready got=%b exp=0010", req_ready);
        end
        step();
        req_val = '0;
        n_cmp++;
        if (ser_val !== 1'b1 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_load got val=%b err=%b exp 1/0", ser_val, err);
        end
        step();
        n_cmp++;
        if (err !== 1'b1 || owner_val !== 1'b1 || done !== 4'b0000) begin
            n_bad++;
            $display("FAIL err_pulse got err=%b ov=%b done=%b exp 1/1/0000", err, owner_val, done);
        end
        step();
        n_cmp++;
        if (err !== 1'b0 || owner_val !== 1'b0) begin
            n_bad++;
            $display("FAIL err_return got err=%b ov=%b exp 0/0", err, owner_val);
        end
        req_val = 4'b0010;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL err_idle_ready got=%b exp=0010", req_ready);
        end
        req_val = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            done_seen = done_seen | done;
        end
        n_cmp++;
        if (done_seen !== 4'b0000) begin
            n_bad++;
            $display("FAIL err_no_done got=%b exp=0000", done_seen);
        end
        never_busy = 1'b0;
    endtask

    task automatic test_issue_hold();
        logic [15:0] w = 16'($urandom);
        ext_busy = 1'b1;
        busy_len = 2;
        req_data[15:0] = w;
        req_mod[3:0] = 4'd0;
        req_val = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL hold_ready got=%b exp=0001", req_ready);
        end
        step();
        req_val = '0;
        n_cmp++;
        if (ser_val !== 1'b0 || owner_val !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_wait1 got val=%b ov=%b exp 0/1", ser_val, owner_val);
        end
        step();
        n_cmp++;
        if (ser_val !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_wait2 got val=%b exp 0", ser_val);
        end
        ext_busy = 1'b0;
        #1;
        n_cmp++;
        if (ser_val !== 1'b1 || ser_data !== w) begin
            n_bad++;
            $display("FAIL hold_release got val=%b data=%h exp 1/%h", ser_val, ser_data, w);
        end
        step();
        wait_idle("hold");
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] done_seen = '0;
        logic ov_seen = 1'b0;
        req_mod[11:8] = 4'd0;
        req_val = 4'b0100;
        busy_len = 30;
        step();
        req_val = '0;
        repeat (4) step();
        req_val = 4'hF;
        #2 arst = 1'b1;
        #1;
        n_cmp++;
        if ({ser_val, ser_data, ser_mod, owner, owner_val, done, drop, err, req_ready} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs got val=%b data=%h mod=%h own=%h ov=%b done=%b drop=%b err=%b rdy=%b exp all 0",
                     ser_val, ser_data, ser_mod, owner, owner_val, done, drop, err, req_ready);
        end
        @(posedge clk);
        @(posedge clk);
        #1 arst = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL midreset_priority got=%b exp=0001", req_ready);
        end
        req_val = '0;
        for (int k = 0; k < 40; k++) begin
            step();
            done_seen = done_seen | done;
            ov_seen = ov_seen | owner_val;
        end
        n_cmp++;
        if (done_seen !== 4'b0000 || ov_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_no_done got done=%b ov=%b exp 0000/0", done_seen, ov_seen);
        end
    endtask

    task automatic test_data_change();
        logic [15:0] x = 16'($urandom);
        req_data[31:16] = x;
        req_mod[7:4] = 4'd7;
        req_val = 4'b0010;
        busy_len = 3;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL hold_data_ready got=%b exp=0010", req_ready);
        end
        step();
        req_data[31:16] = ~x;
        req_mod[7:4] = 4'd3;
        req_val = '0;
        #1;
        n_cmp++;
        if (ser_data !== x || ser_mod !== 4'd7) begin
            n_bad++;
            $display("FAIL data_sampled1 got data=%h mod=%0d exp %h/7", ser_data, ser_mod, x);
        end
        step();
        n_cmp++;
        if (ser_data !== x || ser_mod !== 4'd7) begin
            n_bad++;
            $display("FAIL data_sampled2 got data=%h mod=%0d exp %h/7", ser_data, ser_mod, x);
        end
        wait_idle("data");
    endtask

    // Model: winner from plain modulo search; all event times from cycle arithmetic.
    task automatic test_random();
        int m_last = N - 1;
        int m_free = 0;
        int ev_val = -1, ev_done = -1, ev_drop = -1, ev_err = -1;
        int own_lo = -1, own_hi = -2;
        int e_own = 0;
        int w = 0;
        logic [N-1:0] e_done_m = '0, e_drop_m = '0, e_ready;
        logic [15:0]  e_data = '0;
        logic [3:0]   e_mod = '0, code;
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            n_cmp++;
            if (ser_val !== (c == ev_val)) begin
                n_bad++;
                $display("FAIL rand_ser_val cyc=%0d got=%b exp=%b", c, ser_val, (c == ev_val));
            end
            if (c == ev_val) begin
                n_cmp++;
                if (ser_data !== e_data || ser_mod !== e_mod || owner !== e_own[1:0]) begin
                    n_bad++;
                    $display("FAIL rand_load cyc=%0d got %h/%0d/%0d exp %h/%0d/%0d",
                             c, ser_data, ser_mod, owner, e_data, e_mod, e_own);
                end
            end
            n_cmp++;
            if (owner_val !== (c >= own_lo && c <= own_hi)) begin
                n_bad++;
                $display("FAIL rand_owner_val cyc=%0d got=%b", c, owner_val);
            end
            n_cmp++;
            if (done !== ((c == ev_done) ? e_done_m : 4'b0000)) begin
                n_bad++;
                $display("FAIL rand_done cyc=%0d got=%b", c, done);
            end
            n_cmp++;
            if (drop !== ((c == ev_drop) ? e_drop_m : 4'b0000)) begin
                n_bad++;
                $display("FAIL rand_drop cyc=%0d got=%b", c, drop);
            end
            n_cmp++;
            if (err !== (c == ev_err)) begin
                n_bad++;
                $display("FAIL rand_err cyc=%0d got=%b", c, err);
            end

            req_val = 4'($urandom_range(0, 15));
            req_data = {$urandom, $urandom};
            req_mod = 16'($urandom);
            #1;
            e_ready = '0;
            if (c >= m_free && req_val != 4'b0000) begin
                for (int i = 1; i <= N; i++) begin
                    w = (m_last + i) % N;
                    if (req_val[w]) break;
                end
                e_ready = 4'(1 << w);
                code = req_mod[4*w +: 4];
                m_last = w;
                if (code == 4'd1 || code == 4'd2) begin
                    ev_drop = c + 1;
                    e_drop_m = e_ready;
                    m_free = c + 1;
                end else begin
                    ev_val = c + 1;
                    e_data = req_data[16*w +: 16];
                    e_mod = code;
                    e_own = w;
                    own_lo = c + 1;
                    if ($urandom_range(0, 9) == 0) begin
                        never_busy = 1'b1;
                        ev_err = c + 2;
                        m_free = c + 3;
                    end else begin
                        never_busy = 1'b0;
                        busy_len = $urandom_range(1, 6);
                        ev_done = c + busy_len + 3;
                        e_done_m = e_ready;
                        m_free = ev_done;
                    end
                    own_hi = m_free - 1;
                end
            end
            n_cmp++;
            if (req_ready !== e_ready) begin
                n_bad++;
                $display("FAIL rand_ready cyc=%0d got=%b exp=%b val=%b", c, req_ready, e_ready, req_val);
            end
            step();
        end
        req_val = '0;
        never_busy = 1'b0;
        wait_idle("rand");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_err();
        test_issue_hold();
        test_reset_mid();
        test_data_change();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
